// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad datapath: key op codes and
// the digit-entry handshake state machine encoding.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_DIGIT     = 3'b000,
    OP_BACKSPACE = 3'b001,
    OP_CLEAR     = 3'b010,
    OP_SIGN      = 3'b011,
    OP_LOAD      = 3'b100
  } key_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/digit_msd_count.sv
// Priority encoder: number of significant digits in a packed digit vector,
// i.e. index of the highest nonzero digit plus one (0 when all digits are 0).
module digit_msd_count #(
  parameter int unsigned NDIG = 10,
  parameter int unsigned DW   = 4,
  localparam int unsigned CW  = $clog2(NDIG + 1)
) (
  input  logic [NDIG*DW-1:0] data,
  output logic [CW-1:0]      count
);

  // Scan upward so the highest nonzero digit wins.
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (data[i*DW +: DW] != '0) begin
        count = CW'(i + 1);
      end
    end
  end

endmodule

// File: rtl/digit_entry_reg.sv
// Keypad digit-entry register. Accepts one key per press over valid/ready,
// executes it one cycle later and waits for the key to be released before
// accepting the next one, so a held key never auto-repeats.
module digit_entry_reg
  import calc_pkg::*;
#(
  parameter int unsigned NDIG  = 10,
  parameter int unsigned DW    = 4,
  parameter int unsigned RADIX = 16,
  localparam int unsigned CW   = $clog2(NDIG + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic [2:0]         key_op,
  input  logic [DW-1:0]      key_digit,
  input  logic [NDIG*DW-1:0] load_data,
  output logic [NDIG*DW-1:0] digits,
  output logic [CW-1:0]      count,
  output logic               negative,
  output logic               full,
  output logic               empty,
  output logic               err
);

  state_e              state_q;
  logic [2:0]          op_q;
  logic [DW-1:0]       digit_q;
  logic [NDIG*DW-1:0]  load_q;
  logic [NDIG*DW-1:0]  digits_q;
  logic [CW-1:0]       count_q;
  logic                neg_q;
  logic                err_q;

  logic                digit_bad;
  logic                load_bad;
  logic [CW-1:0]       load_count;

  assign key_ready = (state_q == ST_IDLE);
  assign full      = (count_q == CW'(NDIG));
  assign empty     = (count_q == '0);
  assign digits    = digits_q;
  assign count     = count_q;
  assign negative  = neg_q;
  assign err       = err_q;

  digit_msd_count #(
    .NDIG (NDIG),
    .DW   (DW)
  ) u_msd (
    .data  (load_q),
    .count (load_count)
  );

  // Range checks on the latched key digit and every latched load digit.
  always_comb begin
    digit_bad = (32'(digit_q) >= RADIX);
    load_bad  = 1'b0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (32'(load_q[i*DW +: DW]) >= RADIX) begin
        load_bad = 1'b1;
      end
    end
  end

  // Handshake FSM and operand state; the key commits on the EXEC->RELEASE edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      digit_q  <= '0;
      load_q   <= '0;
      digits_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (clear) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      digit_q  <= '0;
      load_q   <= '0;
      digits_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // err is a single-cycle pulse
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (key_valid) begin
            op_q    <= key_op;
            digit_q <= key_digit;
            load_q  <= load_data;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state_q <= ST_RELEASE;
          case (op_q)
            OP_DIGIT: begin
              if (digit_bad || full) begin
                err_q <= 1'b1;
              end else if (!(empty && digit_q == '0)) begin
                // Leading zeros are dropped so count tracks significant digits.
                digits_q <= {digits_q[(NDIG-1)*DW-1:0], digit_q};
                count_q  <= count_q + CW'(1);
              end
            end
            OP_BACKSPACE: begin
              if (!empty) begin
                digits_q <= {{DW{1'b0}}, digits_q[NDIG*DW-1:DW]};
                count_q  <= count_q - CW'(1);
                if (count_q == CW'(1)) begin
                  neg_q <= 1'b0;
                end
              end
            end
            OP_CLEAR: begin
              digits_q <= '0;
              count_q  <= '0;
              neg_q    <= 1'b0;
            end
            OP_SIGN: begin
              if (!empty) begin
                neg_q <= ~neg_q;
              end
            end
            OP_LOAD: begin
              if (load_bad) begin
                err_q <= 1'b1;
              end else begin
                digits_q <= load_q;
                count_q  <= load_count;
                // A loaded zero is never negative.
                if (load_count == '0) begin
                  neg_q <= 1'b0;
                end
              end
            end
            default: err_q <= 1'b1;
          endcase
        end
        ST_RELEASE: begin
          if (!key_valid) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_entry_reg.sv
// Bench for digit_entry_reg: a RADIX=16 and a RADIX=10 instance share one key
// stream and are both compared against a numeric reference model that holds
// the operand as a single integer value plus a sign bit.
module tb_digit_entry_reg;
  import calc_pkg::*;

  localparam int NDIG = 10;
  localparam int DW   = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear;
  logic        key_valid;
  logic [2:0]  key_op;
  logic [3:0]  key_digit;
  logic [39:0] load_data;

  logic [39:0] dig_o   [2];
  logic [3:0]  cnt_o   [2];
  logic        neg_o   [2];
  logic        full_o  [2];
  logic        empty_o [2];
  logic        err_o   [2];
  logic        ready_o [2];

  int checks = 0;
  int errors = 0;

  // Reference model state per instance
  longint unsigned mval [2];
  bit              mneg [2];
  bit              merr [2];
  int              radix [2] = '{16, 10};

  always #5 clock = ~clock;

  digit_entry_reg #(.NDIG(NDIG), .DW(DW), .RADIX(16)) dut16 (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .key_valid (key_valid),
    .key_ready (ready_o[0]),
    .key_op    (key_op),
    .key_digit (key_digit),
    .load_data (load_data),
    .digits    (dig_o[0]),
    .count     (cnt_o[0]),
    .negative  (neg_o[0]),
    .full      (full_o[0]),
    .empty     (empty_o[0]),
    .err       (err_o[0])
  );

  digit_entry_reg #(.NDIG(NDIG), .DW(DW), .RADIX(10)) dut10 (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .key_valid (key_valid),
    .key_ready (ready_o[1]),
    .key_op    (key_op),
    .key_digit (key_digit),
    .load_data (load_data),
    .digits    (dig_o[1]),
    .count     (cnt_o[1]),
    .negative  (neg_o[1]),
    .full      (full_o[1]),
    .empty     (empty_o[1]),
    .err       (err_o[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Significant base-16 digits in a value.
  function automatic int ndigits(input longint unsigned v);
    int n = 0;
    while (v != 0) begin
      v = v >> 4;
      n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mval[i] = 0;
      mneg[i] = 0;
      merr[i] = 0;
    end
  endtask

  task automatic model_apply(input int i, input logic [2:0] op, input logic [3:0] d,
                             input logic [39:0] ld);
    bit bad;
    merr[i] = 0;
    case (op)
      3'd0: begin
        if (int'(d) >= radix[i] || ndigits(mval[i]) == NDIG) merr[i] = 1;
        else mval[i] = mval[i] * 16 + longint'(d);
      end
      3'd1: begin
        if (mval[i] != 0) begin
          mval[i] = mval[i] / 16;
          if (mval[i] == 0) mneg[i] = 0;
        end
      end
      3'd2: begin
        mval[i] = 0;
        mneg[i] = 0;
      end
      3'd3: if (mval[i] != 0) mneg[i] = !mneg[i];
      3'd4: begin
        bad = 0;
        for (int k = 0; k < NDIG; k++) if (int'(ld[k*4 +: 4]) >= radix[i]) bad = 1;
        if (bad) merr[i] = 1;
        else begin
          mval[i] = longint'(ld);
          if (ld == 0) mneg[i] = 0;
        end
      end
      default: merr[i] = 1;
    endcase
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s.r%0d.digits", tag, radix[i]), 64'(dig_o[i]), mval[i]);
      check($sformatf("%s.r%0d.count", tag, radix[i]), 64'(cnt_o[i]), 64'(ndigits(mval[i])));
      check($sformatf("%s.r%0d.negative", tag, radix[i]), 64'(neg_o[i]), 64'(mneg[i]));
      check($sformatf("%s.r%0d.err", tag, radix[i]), 64'(err_o[i]), 64'(merr[i]));
      check($sformatf("%s.r%0d.full", tag, radix[i]), 64'(full_o[i]),
            64'(ndigits(mval[i]) == NDIG));
      check($sformatf("%s.r%0d.empty", tag, radix[i]), 64'(empty_o[i]), 64'(mval[i] == 0));
    end
  endtask

  task automatic check_ready(input string tag, input logic [1:0] exp);
    check(tag, 64'({ready_o[1], ready_o[0]}), 64'(exp));
  endtask

  // One complete key press: present, accept, commit, hold, release.
  task automatic press(input logic [2:0] op, input logic [3:0] d, input logic [39:0] ld,
                       input int hold, output logic [1:0] err_seen);
    int n;
    @(negedge clock);
    key_valid = 1'b1;
    key_op    = op;
    key_digit = d;
    load_data = ld;
    n = 0;
    while (!(ready_o[0] && ready_o[1]) && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_ready("ready_idle", 2'b11);
    @(posedge clock); #1;
    check_ready("ready_exec", 2'b00);
    @(posedge clock); #1;
    err_seen = {err_o[1], err_o[0]};
    for (int i = 0; i < 2; i++) model_apply(i, op, d, ld);
    check_all("commit");
    if (hold > 0) begin
      repeat (hold) @(posedge clock);
      #1;
      check_ready("ready_held", 2'b00);
      for (int i = 0; i < 2; i++) merr[i] = 0;
      check_all("held");
    end
    @(negedge clock);
    key_valid = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 2; i++) merr[i] = 0;
    check_ready("ready_release", 2'b11);
    check_all("release");
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  d;
    logic [39:0] ld;
    int          cnt;
    logic [39:0] dig;
    bit          neg;
    bit          err16;
    bit          err10;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] op, input logic [3:0] d, input logic [39:0] ld,
                              input int cnt, input logic [39:0] dig, input bit neg,
                              input bit e16, input bit e10);
    vec_t v;
    v.op = op; v.d = d; v.ld = ld; v.cnt = cnt; v.dig = dig; v.neg = neg;
    v.err16 = e16; v.err10 = e10;
    return v;
  endfunction

  vec_t tbl [19];

  initial begin
    #1000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  es;
    logic [39:0] ld;
    int          r;
    int          top;
    bit          lim9;

    // Expected outputs of the RADIX=16 instance after each press, plus both err pulses.
    tbl[0]  = mk(3'd0, 4'd1, 40'h0, 1, 40'h1, 0, 0, 0);
    tbl[1]  = mk(3'd0, 4'd2, 40'h0, 2, 40'h12, 0, 0, 0);
    tbl[2]  = mk(3'd0, 4'd3, 40'h0, 3, 40'h123, 0, 0, 0);
    tbl[3]  = mk(3'd2, 4'd0, 40'h0, 0, 40'h0, 0, 0, 0);
    tbl[4]  = mk(3'd0, 4'd0, 40'h0, 0, 40'h0, 0, 0, 0);
    tbl[5]  = mk(3'd0, 4'd5, 40'h0, 1, 40'h5, 0, 0, 0);
    tbl[6]  = mk(3'd2, 4'd0, 40'h0, 0, 40'h0, 0, 0, 0);
    tbl[7]  = mk(3'd0, 4'd7, 40'h0, 1, 40'h7, 0, 0, 0);
    tbl[8]  = mk(3'd0, 4'd8, 40'h0, 2, 40'h78, 0, 0, 0);
    tbl[9]  = mk(3'd3, 4'd0, 40'h0, 2, 40'h78, 1, 0, 0);
    tbl[10] = mk(3'd1, 4'd0, 40'h0, 1, 40'h7, 1, 0, 0);
    tbl[11] = mk(3'd1, 4'd0, 40'h0, 0, 40'h0, 0, 0, 0);
    tbl[12] = mk(3'd1, 4'd0, 40'h0, 0, 40'h0, 0, 0, 0);
    tbl[13] = mk(3'd0, 4'hc, 40'h0, 1, 40'hc, 0, 0, 1);
    tbl[14] = mk(3'd5, 4'd0, 40'h0, 1, 40'hc, 0, 1, 1);
    tbl[15] = mk(3'd2, 4'd0, 40'h0, 0, 40'h0, 0, 0, 0);
    tbl[16] = mk(3'd4, 4'd0, 40'h00_0000_0a05, 3, 40'ha05, 0, 0, 1);
    tbl[17] = mk(3'd3, 4'd0, 40'h0, 3, 40'ha05, 1, 0, 0);
    tbl[18] = mk(3'd4, 4'd0, 40'h0, 0, 40'h0, 0, 0, 0);

    reset     = 1'b0;
    clear     = 1'b0;
    key_valid = 1'b0;
    key_op    = 3'd0;
    key_digit = 4'd0;
    load_data = 40'd0;
    model_reset();
    #12;
    check_all("reset");
    check_ready("reset_ready", 2'b11);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      press(tbl[i].op, tbl[i].d, tbl[i].ld, 0, es);
      check($sformatf("tbl%0d.digits", i), 64'(dig_o[0]), 64'(tbl[i].dig));
      check($sformatf("tbl%0d.count", i), 64'(cnt_o[0]), 64'(tbl[i].cnt));
      check($sformatf("tbl%0d.negative", i), 64'(neg_o[0]), 64'(tbl[i].neg));
      check($sformatf("tbl%0d.err16", i), 64'(es[0]), 64'(tbl[i].err16));
      check($sformatf("tbl%0d.err10", i), 64'(es[1]), 64'(tbl[i].err10));
    end

    // Fill to NDIG digits, then one more must be rejected.
    press(3'd2, 4'd0, 40'd0, 0, es);
    for (int i = 0; i < NDIG; i++) press(3'd0, 4'($urandom_range(1, 9)), 40'd0, 0, es);
    press(3'd0, 4'd4, 40'd0, 0, es);
    check("overflow.err", 64'(es), 64'(2'b11));
    check("overflow.count", 64'(cnt_o[0]), 64'(NDIG));
    check("overflow.full", 64'(full_o[0]), 64'(1));

    // A key held for 20 cycles shifts exactly once.
    press(3'd2, 4'd0, 40'd0, 0, es);
    press(3'd0, 4'd4, 40'd0, 20, es);
    check("held.digits", 64'(dig_o[0]), 64'h4);
    check("held.count", 64'(cnt_o[0]), 64'd1);

    // Asynchronous reset while a key sits in EXEC.
    @(negedge clock);
    key_valid = 1'b1;
    key_op    = 3'd0;
    key_digit = 4'd9;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("reset_exec");
    check_ready("reset_exec_ready", 2'b11);
    @(negedge clock);
    key_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clock); #1;
    check_all("reset_exec_after");
    check_ready("reset_exec_after_ready", 2'b11);

    // Synchronous clear while waiting for release.
    press(3'd0, 4'd6, 40'd0, 0, es);
    @(negedge clock);
    key_valid = 1'b1;
    key_op    = 3'd0;
    key_digit = 4'd2;
    @(posedge clock);
    @(posedge clock); #1;
    for (int i = 0; i < 2; i++) model_apply(i, 3'd0, 4'd2, 40'd0);
    check_all("pre_clear");
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    model_reset();
    check_all("clear_release");
    check_ready("clear_release_ready", 2'b11);
    @(negedge clock);
    clear     = 1'b0;
    key_valid = 1'b0;
    @(posedge clock); #1;
    check_all("clear_after");
    check_ready("clear_after_ready", 2'b11);

    // Random key stream against the model.
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      if (r < 45) key_op = 3'd0;
      else if (r < 60) key_op = 3'd1;
      else if (r < 64) key_op = 3'd2;
      else if (r < 74) key_op = 3'd3;
      else if (r < 92) key_op = 3'd4;
      else key_op = 3'($urandom_range(5, 7));
      lim9 = ($urandom_range(0, 1) == 1);
      top  = $urandom_range(0, 10);
      ld   = '0;
      for (int k = 0; k < NDIG; k++) begin
        if (k < top) ld[k*4 +: 4] = lim9 ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
      end
      press(key_op, 4'($urandom_range(0, 15)), ld, $urandom_range(0, 3), es);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
